icache_fifo_reader: RTL and testbench
=====================================

Name: icache_fifo_reader

Overview:
Consumer side of the 8-entry instruction-fetch FIFO. Each cycle it inspects the FIFO head through the pre-read view and pops it only when the entry's state field allows. It presents fetched instructions to decode over a valid/ready handshake with a one-entry output register. It also drives the FIFO's flush and state write-back ports.

Parameters:
FIFOWIDE, 68, entry width. Fixed layout: [67:36] pc, [35:4] inst, [3:2] state, [1] pred_taken, [0] rsvd.
TIMEOUT, 64, cycles a head entry may stay PENDING before being forced to ERROR (used only with the optional feature).

Ports:
Clk  in  1  clock
Rest  in  1  asynchronous active-low reset
FifoPreOut  in  FIFOWIDE  head entry, valid whenever FifoEmpty=0
FifoPrePtr  in  3  head index
FifoEmpty  in  1  FIFO empty
Rable  out  1  pop head this cycle (combinational)
StateWAble  out  1  state write-back strobe
StatePtr  out  3  write-back index
StateDate  out  2  write-back value
FifoClean  out  1  reset FIFO pointers (combinational)
Flush  in  1  pipeline redirect
OutValid  out  1  decode entry valid
OutReady  in  1  decode accepts
OutPc  out  32  pc
OutInst  out  32  instruction
OutPredTaken  out  1  predicted-taken bit
OutExcp  out  1  entry carries a fetch error

Behaviour:
- Reset values: Rest=0 asynchronously clears OutValid, OutPc, OutInst, OutPredTaken, OutExcp, the FSM state and the timeout counter. StateWAble=0, Rable=0, FifoClean=0.
- State encoding: 00 PENDING (refill outstanding), 01 READY, 10 ERROR, 11 KILLED.
- slot_free = !OutValid || OutReady.
- FSM states:
  - IDLE: FIFO empty. Leaves when FifoEmpty=0 and head.state=PENDING.
  - WAIT: head is PENDING. Counter increments each cycle. The FSM returns to IDLE once head.state≠PENDING, or once the FIFO is empty.
  - Pops can occur from IDLE or WAIT. No extra state is used for a pop, so throughput is 1 entry per cycle.
- Pop rule, combinational, in the same cycle:
  - Rable=1 iff FifoEmpty=0, Flush=0, head.state≠PENDING, and (head.state=KILLED or slot_free).
- On a pop of READY or ERROR, the output register loads on the next edge: OutValid=1, OutPc, OutInst and OutPredTaken from the head, OutExcp=(state==ERROR).
- On a pop of KILLED, the entry is discarded. The output register is untouched, so a KILLED entry pops even while output is stalled.
- If OutReady=1 and no load occurs, OutValid clears next edge.
- Latency: FIFO head to OutValid is 1 cycle. Back-to-back READY entries stream at 1 per cycle while OutReady=1.
- Output stall: while OutValid=1 and OutReady=0, the output register holds stable and no READY/ERROR pop occurs.
- Flush: FifoClean=Flush in the same cycle, and Rable is forced 0. Next edge: OutValid=0, FSM=IDLE, counter=0. Flush takes priority over OutReady and over any pop.
- Flush and timeout write-back in the same cycle: write-back is suppressed.
- Head pointer wrap 7→0 is handled entirely by the FIFO. The reader uses FifoPrePtr only as StatePtr.
- Reset mid-stream: output is dropped. The FIFO is reset by the same Rest.

Optional Feature:
ICACHE_READER_TIMEOUT_EN
- Defined: in WAIT, when the counter reaches TIMEOUT-1, the block pulses StateWAble=1, StatePtr=FifoPrePtr, StateDate=2'b10 for one cycle and clears the counter. Next cycle the head is ERROR and pops as an exception.
- Undefined: the counter is not built, StateWAble is tied to 0, and WAIT lasts indefinitely.

Decomposition:
- Shared package icache_pkg holds:
  - entry field offsets (PC_MSB/LSB, INST_MSB/LSB, ST_MSB/LSB, PT_BIT);
  - state codes ST_PENDING, ST_READY, ST_ERROR, ST_KILLED;
  - reader FSM encodings.
- One natural sub-module: icache_out_reg, the valid/ready output register with load, hold and clear.

Test Plan:
- Stream 8 READY entries (pc 0x1c000000 step 4), OutReady=1 → OutValid on 8 consecutive cycles starting 1 cycle after the first entry, pc values in order, Rable high 8 cycles, pointer wrap 7→0 clean.
- Head PENDING for 5 cycles, then updated to READY → Rable=0 for 5 cycles, pop on cycle 6, OutValid on cycle 7.
- KILLED, READY, KILLED, READY with OutReady=0 → both KILLED entries dropped. First READY held on output and stable; second READY pops only after OutReady rises.
- Flush asserted while OutValid=1, 3 entries queued → FifoClean=1 and Rable=0 in the same cycle. OutValid=0 next cycle, FSM=IDLE.
- With ICACHE_READER_TIMEOUT_EN and TIMEOUT=4, head PENDING indefinitely → StateWAble pulse on 4th WAIT cycle with StatePtr=head index and StateDate=2'b10. Entry is then output with OutExcp=1.
- Rest asserted mid-stream with OutValid=1 → all outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg: shared definitions for the instruction-fetch FIFO reader.
// Entry layout (68 bits): [67:36] pc, [35:4] inst, [3:2] state,
// [1] pred_taken, [0] reserved.
package icache_pkg;

    // Entry geometry
    localparam int ENTRY_W  = 68;
    localparam int PC_MSB   = 67;
    localparam int PC_LSB   = 36;
    localparam int INST_MSB = 35;
    localparam int INST_LSB = 4;
    localparam int ST_MSB   = 3;
    localparam int ST_LSB   = 2;
    localparam int PT_BIT   = 1;
    localparam int RSVD_BIT = 0;

    // Per-entry refill state codes
    localparam logic [1:0] ST_PENDING = 2'b00;  // refill still outstanding
    localparam logic [1:0] ST_READY   = 2'b01;  // instruction valid
    localparam logic [1:0] ST_ERROR   = 2'b10;  // fetch error, deliver as exception
    localparam logic [1:0] ST_KILLED  = 2'b11;  // squashed, drop silently

    // Reader FSM encodings
    localparam logic [0:0] RD_IDLE = 1'b0;      // no pending head
    localparam logic [0:0] RD_WAIT = 1'b1;      // head entry is PENDING

    // Extract the state field of a FIFO entry
    function automatic logic [1:0] entry_state(input logic [ENTRY_W-1:0] entry);
        return entry[ST_MSB:ST_LSB];
    endfunction

endpackage

// File: rtl/icache_out_reg.sv
// icache_out_reg: one-entry output register toward decode.
// Handshake: o_valid/i_ready; a transfer happens on a clock edge where both
// are high. While o_valid=1 and i_ready=0 all payload outputs hold stable.
// i_clr has priority over i_load; i_load has priority over the ready-clear.
module icache_out_reg (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic        i_clr,
    input  logic        i_ready,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_inst,
    input  logic        i_pt,
    input  logic        i_excp,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_inst,
    output logic        o_pt,
    output logic        o_excp
);

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_pt;
    logic        r_excp;

    // Valid flag: clear on flush, set on load, drop once decode takes it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Payload: captured only on a load, otherwise held
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc   <= 32'd0;
            r_inst <= 32'd0;
            r_pt   <= 1'b0;
            r_excp <= 1'b0;
        end else if (i_load && !i_clr) begin
            r_pc   <= i_pc;
            r_inst <= i_inst;
            r_pt   <= i_pt;
            r_excp <= i_excp;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_inst  = r_inst;
    assign o_pt    = r_pt;
    assign o_excp  = r_excp;

endmodule

// File: rtl/icache_fifo_reader.sv
// icache_fifo_reader: consumer side of the 8-entry instruction-fetch FIFO.
// Pops the head when its state allows, feeds decode through a one-entry
// output register, and drives the FIFO flush and state write-back ports.
// Optional build macro ICACHE_READER_TIMEOUT_EN adds a PENDING watchdog
// (TIMEOUT cycles) that rewrites a stuck head entry to ERROR.
module icache_fifo_reader
    import icache_pkg::*;
#(
    parameter int FIFOWIDE = ENTRY_W,
    parameter int TIMEOUT  = 64
) (
    input  logic                Clk,
    input  logic                Rest,
    input  logic [FIFOWIDE-1:0] FifoPreOut,
    input  logic [2:0]          FifoPrePtr,
    input  logic                FifoEmpty,
    output logic                Rable,
    output logic                StateWAble,
    output logic [2:0]          StatePtr,
    output logic [1:0]          StateDate,
    output logic                FifoClean,
    input  logic                Flush,
    output logic                OutValid,
    input  logic                OutReady,
    output logic [31:0]         OutPc,
    output logic [31:0]         OutInst,
    output logic                OutPredTaken,
    output logic                OutExcp,
    output logic [0:0]          o_dbg_state
);

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [1:0] w_head_st;
    logic       w_head_pend;
    logic       w_slot_free;
    logic       w_pop;
    logic       w_load;
    logic       w_unused_rsvd;

    assign w_head_st     = entry_state(FifoPreOut);
    assign w_head_pend   = !FifoEmpty && (w_head_st == ST_PENDING);
    assign w_unused_rsvd = FifoPreOut[RSVD_BIT];

    // Output slot can take a new entry if empty or being drained this cycle
    assign w_slot_free = !OutValid || OutReady;

    // Pop decision: KILLED entries drop even under output stall,
    // READY/ERROR entries need a free output slot. Flush blocks all pops.
    // Gated by Rest so the FIFO sees no pop strobe while held in reset.
    assign w_pop = Rest && !FifoEmpty && !Flush &&
                   (w_head_st != ST_PENDING) &&
                   ((w_head_st == ST_KILLED) || w_slot_free);

    // Only deliverable entries load the output register
    assign w_load = w_pop && ((w_head_st == ST_READY) || (w_head_st == ST_ERROR));

    assign Rable     = w_pop;
    assign FifoClean = Flush && Rest;

    // Write-back always targets the head; the only value ever written is ERROR
    assign StatePtr  = FifoPrePtr;
    assign StateDate = ST_ERROR;

    // Next-state: track whether the head is waiting on a refill
    always_comb begin
        w_state_nxt = r_state;
        if (Flush) begin
            w_state_nxt = RD_IDLE;
        end else begin
            case (r_state)
                RD_IDLE: if (w_head_pend)  w_state_nxt = RD_WAIT;
                RD_WAIT: if (!w_head_pend) w_state_nxt = RD_IDLE;
                default: w_state_nxt = RD_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            r_state <= RD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign o_dbg_state = r_state;

`ifdef ICACHE_READER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_timeout;

    // Head has sat PENDING for TIMEOUT cycles of WAIT
    assign w_timeout = (r_state == RD_WAIT) && w_head_pend &&
                       (r_wait_cnt == CNT_W'(TIMEOUT - 1));

    // Wait counter: runs only in WAIT, restarts on timeout, flush or exit
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            r_wait_cnt <= '0;
        end else if (Flush || (r_state != RD_WAIT) || w_timeout) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    // A flush in the same cycle wins: the entry is going away anyway
    assign StateWAble = w_timeout && !Flush && Rest;
`else
    assign StateWAble = 1'b0;
`endif

    icache_out_reg u_out_reg (
        .i_clk   (Clk),
        .i_rst_n (Rest),
        .i_load  (w_load),
        .i_clr   (Flush),
        .i_ready (OutReady),
        .i_pc    (FifoPreOut[PC_MSB:PC_LSB]),
        .i_inst  (FifoPreOut[INST_MSB:INST_LSB]),
        .i_pt    (FifoPreOut[PT_BIT]),
        .i_excp  (w_head_st == ST_ERROR),
        .o_valid (OutValid),
        .o_pc    (OutPc),
        .o_inst  (OutInst),
        .o_pt    (OutPredTaken),
        .o_excp  (OutExcp)
    );

endmodule

// File: tb/tb_icache_fifo_reader.sv
// tb_icache_fifo_reader: directed bench for icache_fifo_reader. A small
// queue stands in for the FIFO, reacting to Rable, FifoClean and the
// state write-back strobe sampled at mid-cycle.
module tb_icache_fifo_reader;
    import icache_pkg::*;

`ifdef ICACHE_READER_TIMEOUT_EN
    localparam int PEND_CYC   = 3;
    localparam int TB_TIMEOUT = 4;
`else
    localparam int PEND_CYC   = 5;
    localparam int TB_TIMEOUT = 64;
`endif

    logic        Clk = 1'b0;
    logic        Rest;
    logic [67:0] FifoPreOut;
    logic [2:0]  FifoPrePtr;
    logic        FifoEmpty;
    logic        Rable;
    logic        StateWAble;
    logic [2:0]  StatePtr;
    logic [1:0]  StateDate;
    logic        FifoClean;
    logic        Flush;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] OutPc;
    logic [31:0] OutInst;
    logic        OutPredTaken;
    logic        OutExcp;
    logic [0:0]  o_dbg_state;

    int errors = 0;
    int checks = 0;

    logic [67:0] fifo_q[$];
    logic [2:0]  head_ptr;
    logic        s_rable, s_clean, s_wab;
    logic [2:0]  s_ptr;
    logic [1:0]  s_date;

    always #5 Clk = ~Clk;

    icache_fifo_reader #(.FIFOWIDE(68), .TIMEOUT(TB_TIMEOUT)) dut (
        .Clk(Clk), .Rest(Rest), .FifoPreOut(FifoPreOut), .FifoPrePtr(FifoPrePtr),
        .FifoEmpty(FifoEmpty), .Rable(Rable), .StateWAble(StateWAble),
        .StatePtr(StatePtr), .StateDate(StateDate), .FifoClean(FifoClean),
        .Flush(Flush), .OutValid(OutValid), .OutReady(OutReady), .OutPc(OutPc),
        .OutInst(OutInst), .OutPredTaken(OutPredTaken), .OutExcp(OutExcp),
        .o_dbg_state(o_dbg_state)
    );

    function automatic logic [67:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                       input logic [1:0] st, input logic pt);
        return {pc, inst, st, pt, 1'b0};
    endfunction

    task automatic drive_fifo();
        FifoEmpty  = (fifo_q.size() == 0);
        FifoPreOut = FifoEmpty ? 68'd0 : fifo_q[0];
        FifoPrePtr = head_ptr;
    endtask

    task automatic set_head_state(input logic [1:0] st);
        logic [67:0] tmp;
        tmp = fifo_q[0];
        tmp[3:2] = st;
        fifo_q[0] = tmp;
        drive_fifo();
    endtask

    // One clock: sample strobes at negedge, let the FIFO model react after posedge
    task automatic tick();
        @(negedge Clk);
        s_rable = Rable;
        s_clean = FifoClean;
        s_wab   = StateWAble;
        s_ptr   = StatePtr;
        s_date  = StateDate;
        @(posedge Clk);
        #1;
        if (s_clean) begin
            fifo_q.delete();
            head_ptr = 3'd0;
        end else begin
            if (s_wab && fifo_q.size() > 0 && s_ptr == head_ptr) set_head_state(s_date);
            if (s_rable && fifo_q.size() > 0) begin
                void'(fifo_q.pop_front());
                head_ptr = head_ptr + 3'd1;
            end
        end
        drive_fifo();
    endtask

    task automatic test_reset();
        Rest = 1'b0; Flush = 1'b0; OutReady = 1'b0; head_ptr = 3'd0;
        fifo_q.delete(); drive_fifo();
        repeat (2) @(posedge Clk);
        #1;
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", OutValid); end
        checks++; if (OutPc !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h expected 0", OutPc); end
        checks++; if (OutInst !== 32'd0) begin errors++; $display("FAIL reset_inst: got %h expected 0", OutInst); end
        checks++; if ({OutPredTaken, OutExcp} !== 2'b00) begin errors++; $display("FAIL reset_pt_excp: got %b expected 00", {OutPredTaken, OutExcp}); end
        checks++; if ({Rable, FifoClean, StateWAble} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b expected 000", {Rable, FifoClean, StateWAble}); end
        checks++; if (o_dbg_state !== RD_IDLE) begin errors++; $display("FAIL reset_fsm: got %b expected %b", o_dbg_state, RD_IDLE); end
        Rest = 1'b1;
        tick();
    endtask

    task automatic test_pending();
        OutReady = 1'b1;
        fifo_q.push_back(mk(32'h1c00_1000, 32'h0000_0513, ST_PENDING, 1'b0));
        drive_fifo();
        for (int i = 0; i < PEND_CYC; i++) begin
            tick();
            checks++; if (s_rable !== 1'b0) begin errors++; $display("FAIL pend_rable[%0d]: got %b expected 0", i, s_rable); end
            checks++; if (s_wab !== 1'b0) begin errors++; $display("FAIL pend_wab[%0d]: got %b expected 0", i, s_wab); end
            checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL pend_valid[%0d]: got %b expected 0", i, OutValid); end
        end
        checks++; if (o_dbg_state !== RD_WAIT) begin errors++; $display("FAIL pend_fsm_wait: got %b expected %b", o_dbg_state, RD_WAIT); end
        set_head_state(ST_READY);
        tick();
        checks++; if (s_rable !== 1'b1) begin errors++; $display("FAIL pend_pop: got %b expected 1", s_rable); end
        checks++; if (s_ptr !== 3'd0) begin errors++; $display("FAIL pend_ptr: got %0d expected 0", s_ptr); end
        checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL pend_out_valid: got %b expected 1", OutValid); end
        checks++; if (OutPc !== 32'h1c00_1000) begin errors++; $display("FAIL pend_out_pc: got %h expected 1c001000", OutPc); end
        checks++; if (OutInst !== 32'h0000_0513) begin errors++; $display("FAIL pend_out_inst: got %h expected 00000513", OutInst); end
        checks++; if (o_dbg_state !== RD_IDLE) begin errors++; $display("FAIL pend_fsm_idle: got %b expected %b", o_dbg_state, RD_IDLE); end
        tick();
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL pend_drain: got %b expected 0", OutValid); end
    endtask

    task automatic test_killed();
        logic [3:0] exp_rable;
        OutReady = 1'b0;
        fifo_q.push_back(mk(32'h0000_2000, 32'hdead_0001, ST_KILLED, 1'b0));
        fifo_q.push_back(mk(32'h0000_2004, 32'h1111_0001, ST_READY,  1'b1));
        fifo_q.push_back(mk(32'h0000_2008, 32'hdead_0002, ST_KILLED, 1'b0));
        fifo_q.push_back(mk(32'h0000_200c, 32'h2222_0002, ST_READY,  1'b0));
        drive_fifo();
        tick();
        checks++; if (s_rable !== 1'b1) begin errors++; $display("FAIL kill1_pop: got %b expected 1", s_rable); end
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL kill1_valid: got %b expected 0", OutValid); end
        tick();
        checks++; if (s_rable !== 1'b1) begin errors++; $display("FAIL ready1_pop: got %b expected 1", s_rable); end
        checks++; if (OutValid !== 1'b1 || OutPc !== 32'h0000_2004) begin errors++; $display("FAIL ready1_out: got %b/%h expected 1/00002004", OutValid, OutPc); end
        tick();
        checks++; if (s_rable !== 1'b1) begin errors++; $display("FAIL kill2_pop_stalled: got %b expected 1", s_rable); end
        exp_rable = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            checks++; if (OutValid !== 1'b1 || OutPc !== 32'h0000_2004 || OutInst !== 32'h1111_0001 || OutPredTaken !== 1'b1)
                begin errors++; $display("FAIL stall_hold[%0d]: got %b/%h/%h/%b expected 1/00002004/11110001/1", i, OutValid, OutPc, OutInst, OutPredTaken); end
            tick();
            checks++; if (s_rable !== exp_rable[i]) begin errors++; $display("FAIL stall_rable[%0d]: got %b expected 0", i, s_rable); end
        end
        OutReady = 1'b1;
        tick();
        checks++; if (s_rable !== 1'b1) begin errors++; $display("FAIL ready2_pop: got %b expected 1", s_rable); end
        checks++; if (OutValid !== 1'b1 || OutPc !== 32'h0000_200c) begin errors++; $display("FAIL ready2_out: got %b/%h expected 1/0000200c", OutValid, OutPc); end
        tick();
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL killed_drain: got %b expected 0", OutValid); end
    endtask

    task automatic test_error();
        OutReady = 1'b1;
        fifo_q.push_back(mk(32'h0000_3000, 32'h0000_0073, ST_ERROR, 1'b1));
        drive_fifo();
        tick();
        checks++; if (s_rable !== 1'b1) begin errors++; $display("FAIL err_pop: got %b expected 1", s_rable); end
        checks++; if ({OutValid, OutExcp, OutPredTaken} !== 3'b111) begin errors++; $display("FAIL err_flags: got %b expected 111", {OutValid, OutExcp, OutPredTaken}); end
        checks++; if (OutPc !== 32'h0000_3000) begin errors++; $display("FAIL err_pc: got %h expected 00003000", OutPc); end
        tick();
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL err_drain: got %b expected 0", OutValid); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  start;
        logic [31:0] epc;
        OutReady = 1'b1;
        start = head_ptr;
        for (int i = 0; i < 8; i++)
            fifo_q.push_back(mk(32'h1c00_0000 + 32'(4 * i), 32'h0000_0013 | (32'(i) << 20), ST_READY, 1'(i % 2)));
        drive_fifo();
        for (int k = 0; k < 8; k++) begin
            tick();
            epc = 32'h1c00_0000 + 32'(4 * k);
            checks++; if (s_rable !== 1'b1) begin errors++; $display("FAIL b2b_rable[%0d]: got %b expected 1", k, s_rable); end
            checks++; if (s_ptr !== start + 3'(k)) begin errors++; $display("FAIL b2b_ptr[%0d]: got %0d expected %0d", k, s_ptr, start + 3'(k)); end
            checks++; if (OutValid !== 1'b1 || OutPc !== epc) begin errors++; $display("FAIL b2b_out[%0d]: got %b/%h expected 1/%h", k, OutValid, OutPc, epc); end
            checks++; if (OutInst !== (32'h0000_0013 | (32'(k) << 20)) || OutPredTaken !== 1'(k % 2) || OutExcp !== 1'b0)
                begin errors++; $display("FAIL b2b_payload[%0d]: got %h/%b/%b", k, OutInst, OutPredTaken, OutExcp); end
        end
        tick();
        checks++; if (s_rable !== 1'b0 || OutValid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b/%b expected 0/0", s_rable, OutValid); end
    endtask

    task automatic test_flush();
        OutReady = 1'b0;
        for (int i = 0; i < 4; i++)
            fifo_q.push_back(mk(32'h0000_4000 + 32'(4 * i), 32'h0000_0093, ST_READY, 1'b0));
        drive_fifo();
        tick();
        checks++; if (OutValid !== 1'b1 || OutPc !== 32'h0000_4000) begin errors++; $display("FAIL flush_pre: got %b/%h expected 1/00004000", OutValid, OutPc); end
        Flush = 1'b1; OutReady = 1'b1;
        tick();
        checks++; if (s_clean !== 1'b1 || s_rable !== 1'b0) begin errors++; $display("FAIL flush_strobes: got clean=%b rable=%b expected 1/0", s_clean, s_rable); end
        checks++; if (OutValid !== 1'b0 || o_dbg_state !== RD_IDLE) begin errors++; $display("FAIL flush_out: got %b/%b expected 0/%b", OutValid, o_dbg_state, RD_IDLE); end
        Flush = 1'b0;
        fifo_q.push_back(mk(32'h0000_4100, 32'h0000_0093, ST_PENDING, 1'b0));
        drive_fifo();
        tick(); tick();
        checks++; if (o_dbg_state !== RD_WAIT) begin errors++; $display("FAIL flush_wait_pre: got %b expected %b", o_dbg_state, RD_WAIT); end
        Flush = 1'b1;
        tick();
        checks++; if (o_dbg_state !== RD_IDLE || s_clean !== 1'b1) begin errors++; $display("FAIL flush_wait: got %b/%b expected %b/1", o_dbg_state, s_clean, RD_IDLE); end
        Flush = 1'b0;
        tick();
        checks++; if (FifoClean !== 1'b0 || OutValid !== 1'b0) begin errors++; $display("FAIL flush_release: got %b/%b expected 0/0", FifoClean, OutValid); end
    endtask

`ifdef ICACHE_READER_TIMEOUT_EN
    task automatic test_timeout();
        OutReady = 1'b1;
        fifo_q.push_back(mk(32'h0000_5000, 32'h0000_0113, ST_PENDING, 1'b0));
        drive_fifo();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (s_wab !== 1'b0) begin errors++; $display("FAIL to_early[%0d]: got %b expected 0", i, s_wab); end
        end
        tick();
        checks++; if (s_wab !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b expected 1", s_wab); end
        checks++; if (s_ptr !== head_ptr || s_date !== 2'b10) begin errors++; $display("FAIL to_wb: got %0d/%b expected %0d/10", s_ptr, s_date, head_ptr); end
        tick();
        checks++; if (s_rable !== 1'b1 || s_wab !== 1'b0) begin errors++; $display("FAIL to_pop: got %b/%b expected 1/0", s_rable, s_wab); end
        checks++; if ({OutValid, OutExcp} !== 2'b11 || OutPc !== 32'h0000_5000) begin errors++; $display("FAIL to_out: got %b/%h expected 11/00005000", {OutValid, OutExcp}, OutPc); end
        tick();
    endtask
`endif

    task automatic test_reset_mid();
        OutReady = 1'b0;
        fifo_q.push_back(mk(32'h0000_6000, 32'hdead_beef, ST_ERROR, 1'b1));
        fifo_q.push_back(mk(32'h0000_6004, 32'h0000_0013, ST_READY, 1'b0));
        drive_fifo();
        tick();
        checks++; if ({OutValid, OutExcp, OutPredTaken} !== 3'b111) begin errors++; $display("FAIL rstmid_pre: got %b expected 111", {OutValid, OutExcp, OutPredTaken}); end
        Rest = 1'b0;
        #1;
        checks++; if ({OutValid, OutExcp, OutPredTaken} !== 3'b000) begin errors++; $display("FAIL rstmid_flags: got %b expected 000", {OutValid, OutExcp, OutPredTaken}); end
        checks++; if (OutPc !== 32'd0 || OutInst !== 32'd0) begin errors++; $display("FAIL rstmid_data: got %h/%h expected 0/0", OutPc, OutInst); end
        checks++; if (Rable !== 1'b0 || StateWAble !== 1'b0) begin errors++; $display("FAIL rstmid_strobes: got %b/%b expected 0/0", Rable, StateWAble); end
        fifo_q.delete(); head_ptr = 3'd0; drive_fifo();
        tick();
        Rest = 1'b1;
        tick();
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL rstmid_after: got %b expected 0", OutValid); end
    endtask

    initial begin
        test_reset();
        test_pending();
        test_killed();
        test_error();
        test_back_to_back();
        test_flush();
`ifdef ICACHE_READER_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
